complement_capture: RTL

COMPLEMENT_CAPTURE -- requirements
Module: complement_capture

---
 rtl/complement_pkg.sv | 11 +
 rtl/complement_capture_settle_counter.sv | 35 +++
 rtl/complement_capture.sv | 135 +++++++++++++
 3 files changed

// File: rtl/complement_pkg.sv
// Shared types and constants for the complement capture block.
package complement_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  localparam int unsigned CNT_W   = 4;
  localparam logic [7:0]  MIN_NEG = 8'h80;
endpackage

// File: rtl/complement_capture_settle_counter.sv
// Settle down-counter: loads a start value, decrements while enabled,
// and flags done while the count sits at 1.
module settle_counter
  import complement_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/complement_capture.sv
// Drives an operand to an external complementer, waits a fixed settle time,
// then captures negate/abs result. Optional out_ovf under COMPLEMENT_OVF_EN.
//
// state     | meaning
// ST_IDLE   | ready for an operand, in_ready=1
// ST_SETTLE | operand on cmp_a, waiting for the complementer to settle
// ST_HOLD   | result presented, waiting for out_ready
module complement_capture
  import complement_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_op,
  output logic [7:0] cmp_a,
  input  logic [7:0] cmp_w,
  output logic       out_valid,
`ifdef COMPLEMENT_OVF_EN
  output logic       out_ovf,
`endif
  input  logic       out_ready,
  output logic [7:0] out_data
);

  state_e     state_d, state_q;
  logic [7:0] cmp_a_d, cmp_a_q;
  logic [7:0] out_data_d, out_data_q;
  logic       out_valid_d, out_valid_q;
  logic       in_ready_d, in_ready_q;
  logic       op_d, op_q;
  logic       cnt_load, cnt_en, cnt_done;
  logic       neg_sel;
  logic [7:0] result;
`ifdef COMPLEMENT_OVF_EN
  logic       ovf_d, ovf_q;
`endif

  settle_counter u_settle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  // Abs mode only takes the complement for negative operands.
  assign neg_sel = ~op_q | cmp_a_q[7];
  assign result  = neg_sel ? cmp_w : cmp_a_q;

  always_comb begin
    state_d     = state_q;
    cmp_a_d     = cmp_a_q;
    op_d        = op_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
`ifdef COMPLEMENT_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cmp_a_d    = in_data;
          op_d       = in_op;
          cnt_load   = 1'b1;
          in_ready_d = 1'b0;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          out_data_d  = result;
          out_valid_d = 1'b1;
`ifdef COMPLEMENT_OVF_EN
          ovf_d       = neg_sel && (cmp_a_q == MIN_NEG);
`endif
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmp_a_q     <= '0;
      op_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef COMPLEMENT_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmp_a_q     <= cmp_a_d;
      op_q        <= op_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef COMPLEMENT_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign cmp_a     = cmp_a_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
`ifdef COMPLEMENT_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule
